rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/arb_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/rr_arb_mux.sv | 113 +++++++++++
 tb/tb_rr_arb_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared defaults and index-width helper for the round-robin arbitrated mux.
package arb_mux_pkg;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefNch   = 4;

   // Width of a channel index; never below one bit.
   function automatic int unsigned chan_idx_w(input int unsigned nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// searching upward and wrapping modulo NCH. Grant is one-hot or all zero.
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter int unsigned NCH = DefNch,
   localparam int unsigned IdxW = chan_idx_w(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [IdxW-1:0] ptr,
   output logic [NCH-1:0]  grant
);

   localparam logic [IdxW:0] NchW = (IdxW+1)'(NCH);

   logic            found;
   logic [IdxW:0]   sum;
   logic [IdxW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int unsigned off = 0; off < NCH; off++) begin
         sum = {1'b0, ptr} + (IdxW+1)'(off);
         if (sum >= NchW) begin
            sum = sum - NchW;
         end
         idx = sum[IdxW-1:0];
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrated N:1 mux with a one-entry registered output stage.
// Optional macro RR_ARB_MUX_FORCE_EN adds force_en/force_sel to pin the grant.
module rr_arb_mux
   import arb_mux_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned NCH   = DefNch,
   localparam int unsigned IdxW = chan_idx_w(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [IdxW-1:0]      out_chan,
   input  logic                 out_ready
`ifdef RR_ARB_MUX_FORCE_EN
   ,
   input  logic                 force_en,
   input  logic [IdxW-1:0]      force_sel
`endif
);

   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IdxW-1:0]  chan_q, chan_d;

   logic [NCH-1:0]   rr_grant;
   logic [NCH-1:0]   grant;
   logic             hold_ptr;
   logic             load_en;
   logic             in_xfer;
   logic [WIDTH-1:0] sel_data;
   logic [IdxW-1:0]  sel_idx;
   logic [IdxW-1:0]  ptr_next;

   rr_arbiter #(
      .NCH (NCH)
   ) u_arbiter (
      .req   (in_valid),
      .ptr   (ptr_q),
      .grant (rr_grant)
   );

   always_comb begin
      grant    = rr_grant;
      hold_ptr = 1'b0;
`ifdef RR_ARB_MUX_FORCE_EN
      if (force_en) begin
         grant            = '0;
         grant[force_sel] = in_valid[force_sel];
         hold_ptr         = 1'b1;
      end
`endif
   end

   assign load_en = !valid_q || out_ready;
   // Reset gating keeps in_ready low while rst_n is held, whatever in_valid does.
   assign in_ready = (rst_n && load_en) ? grant : '0;
   assign in_xfer  = |in_ready;

   always_comb begin
      sel_data = '0;
      sel_idx  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
            sel_idx  = sel_idx | IdxW'(i);
         end
      end
   end

   assign ptr_next = (sel_idx == IdxW'(NCH - 1)) ? '0 : sel_idx + IdxW'(1);

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      chan_d  = chan_q;
      ptr_d   = ptr_q;
      if (in_xfer) begin
         valid_d = 1'b1;
         data_d  = sel_data;
         chan_d  = sel_idx;
         if (!hold_ptr) begin
            ptr_d = ptr_next;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_chan  = chan_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomised scoreboard bench for rr_arb_mux (NCH=4, WIDTH=8); covers the
// forced-select feature when RR_ARB_MUX_FORCE_EN is defined.
module tb_rr_arb_mux;

   localparam int NCH   = 4;
   localparam int WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  in_valid = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_chan;
   logic        out_ready = 1'b0;
`ifdef RR_ARB_MUX_FORCE_EN
   logic        force_en = 1'b0;
   logic [1:0]  force_sel = '0;
`endif

   int errors = 0;
   int checks = 0;

   // Expected words {chan, data} accepted but not yet taken downstream.
   logic [9:0] sb_q[$];
   int         mptr = 0;
   bit         force_on = 1'b0;
   int         fsel = 0;

   rr_arb_mux #(
      .WIDTH (WIDTH),
      .NCH   (NCH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_ready (out_ready)
`ifdef RR_ARB_MUX_FORCE_EN
      ,
      .force_en  (force_en),
      .force_sel (force_sel)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, predict the grant from the round-robin rule, commit at the edge.
   task automatic step(input logic [3:0] iv, input logic [31:0] d, input logic ordy);
      logic [3:0] exp;
      int         k;
      bit         load_en;
      @(negedge clk);
      #1;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
`ifdef RR_ARB_MUX_FORCE_EN
      force_en  = force_on;
      force_sel = 2'(fsel);
`endif
      #1;
      exp     = '0;
      k       = -1;
      load_en = (sb_q.size() == 0) || ordy;
      if (load_en) begin
         if (force_on) begin
            if (iv[fsel]) k = fsel;
         end else begin
            for (int off = 0; off < NCH; off++) begin
               int c;
               c = (mptr + off) % NCH;
               if (k < 0 && iv[c]) k = c;
            end
         end
      end
      if (k >= 0) exp[k] = 1'b1;
      check("in_ready", {28'd0, in_ready}, {28'd0, exp});
      @(posedge clk);
      #1;
      if (k >= 0) begin
         sb_q.push_back({2'(k), d[k*8 +: 8]});
         if (!force_on) mptr = (k + 1) % NCH;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_out_chan", {30'd0, out_chan}, 32'd0);
      check("rst_in_ready", {28'd0, in_ready}, 32'd0);
      sb_q.delete();
      mptr = 0;
      @(negedge clk);
      #1;
      in_valid = '0;
      rst_n    = 1'b1;
   endtask

   // Monitor: checks occupancy, hold stability and each word leaving the output register.
   initial begin
      logic       hold_prev;
      logic [7:0] data_prev;
      logic [1:0] chan_prev;
      logic [9:0] e;
      hold_prev = 1'b0;
      data_prev = '0;
      chan_prev = '0;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
            if (hold_prev) begin
               check("hold_data", {24'd0, out_data}, {24'd0, data_prev});
               check("hold_chan", {30'd0, out_chan}, {30'd0, chan_prev});
            end
            if (out_valid && out_ready && sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("out_chan", {30'd0, out_chan}, {30'd0, e[9:8]});
               check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
            end
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
            chan_prev = out_chan;
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   initial begin
      do_reset();
      // Load one word, then reset with it still held.
      step(4'b1111, 32'h13121110, 1'b0);
      step(4'b0000, 32'h0, 1'b0);
      do_reset();
      // Fairness from channel 0 with all channels requesting.
      for (int i = 0; i < 5; i++) step(4'b1111, 32'h13121110, 1'b1);
      // Single requester on channel 2.
      step(4'b0100, 32'h00A50000, 1'b1);
      // Wrap from channel 3 back to channel 0.
      step(4'b1001, 32'h33000030, 1'b1);
      step(4'b1001, 32'h44000040, 1'b1);
      // Backpressure.
      step(4'b0001, 32'h000000C1, 1'b1);
      for (int i = 0; i < 5; i++) step(4'b1111, 32'h5A5B5C5D + i, 1'b0);
      step(4'b1111, 32'h23222120, 1'b1);
      step(4'b1111, 32'h23222120, 1'b1);
`ifdef RR_ARB_MUX_FORCE_EN
      force_on = 1'b1;
      fsel     = 1;
      for (int i = 0; i < 3; i++) step(4'b1111, 32'h71727374 + i, 1'b1);
      force_on = 1'b0;
      step(4'b1111, 32'h81828384, 1'b1);
`endif
      for (int i = 0; i < 300; i++) begin
         step(4'($urandom), $urandom, 1'($urandom_range(0, 9) < 7));
      end
      for (int i = 0; i < 4; i++) step(4'b0000, 32'h0, 1'b1);
      check("drain", sb_q.size(), 32'd0);
      @(negedge clk);
      #5;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
